// File: rtl/image_pipe_if.sv
// image_pipe_if: one image pipe (pixel data plus start/stop/valid/ready).
//   data  - pixel data, DataWidth bits
//   start - first pixel of frame
//   stop  - last pixel of frame
//   valid - producer has a pixel this cycle
//   ready - consumer accepts the pixel this cycle
// master modport drives the pixel, slave modport drives ready.
interface image_pipe_if #(
    parameter int unsigned DataWidth = 24
);
    logic [DataWidth-1:0] data;
    logic                 start;
    logic                 stop;
    logic                 valid;
    logic                 ready;

    modport master (output data, output start, output stop, output valid, input ready);
    modport slave  (input data, input start, input stop, input valid, output ready);
endinterface

// File: rtl/image_frame_arbiter.sv
// image_frame_arbiter: shares one downstream image pipe between two frame sources.
// Grant is held for a whole frame and alternates round-robin between frames. Frame length
// is policed against ImageWidth*ImageHeight so a bad source cannot hog the output.
//   i_clk         - clock, rising edge
//   i_reset       - synchronous active-high reset
//   i_src0/i_src1 - upstream pipes (slave)
//   o_dst         - downstream pipe (master), registered pixel
//   o_grant       - one-hot active source, 2'b00 when idle
//   o_frame_error - one-cycle pulse: frame length violation
//   o_sync_error  - one-cycle pulse: orphan pixel drained while idle
module image_frame_arbiter #(
    parameter int unsigned ImageWidth  = 100,
    parameter int unsigned ImageHeight = 100,
    parameter int unsigned DataWidth   = 24
) (
    input  logic         i_clk,
    input  logic         i_reset,
    image_pipe_if.slave  i_src0,
    image_pipe_if.slave  i_src1,
    image_pipe_if.master o_dst,
    output logic [1:0]   o_grant,
    output logic         o_frame_error,
    output logic         o_sync_error
);
    localparam int unsigned NumPixels  = ImageWidth * ImageHeight;
    localparam int unsigned CountWidth = (NumPixels > 1) ? $clog2(NumPixels) : 1;
    localparam logic [CountWidth-1:0] LastIdx = CountWidth'(NumPixels - 1);

    typedef enum logic {StIdle, StLocked} state_e;

    state_e                r_state, w_state_next;
    logic                  r_last_grant, w_last_grant_next;  // 1: source 1 served last
    logic [CountWidth-1:0] r_count, w_count_next;
    logic [1:0]            r_grant, w_grant_next;
    logic                  r_out_valid, w_out_valid_next;
    logic                  r_out_start, w_out_start_next;
    logic                  r_out_stop, w_out_stop_next;
    logic [DataWidth-1:0]  r_out_data, w_out_data_next;
    logic                  r_frame_error, w_frame_error_next;
    logic                  r_sync_error, w_sync_error_next;

    logic                  w_req0, w_req1, w_drain0, w_drain1;
    logic                  w_out_free, w_sel, w_xfer, w_last;
    logic                  w_ready0, w_ready1;
    logic [DataWidth-1:0]  w_sel_data;
    logic                  w_sel_start, w_sel_stop, w_sel_valid;

    always_comb begin
        w_req0      = i_src0.valid && i_src0.start;
        w_req1      = i_src1.valid && i_src1.start;
        w_drain0    = i_src0.valid && !i_src0.start;
        w_drain1    = i_src1.valid && !i_src1.start;
        // Output register can take a pixel when empty or being emptied this cycle.
        w_out_free  = !r_out_valid || o_dst.ready;
        w_sel       = r_grant[1];
        w_sel_data  = w_sel ? i_src1.data  : i_src0.data;
        w_sel_start = w_sel ? i_src1.start : i_src0.start;
        w_sel_stop  = w_sel ? i_src1.stop  : i_src0.stop;
        w_sel_valid = w_sel ? i_src1.valid : i_src0.valid;
    end

    always_comb begin
        w_state_next       = r_state;
        w_last_grant_next  = r_last_grant;
        w_count_next       = r_count;
        w_grant_next       = r_grant;
        w_out_valid_next   = r_out_valid && !o_dst.ready;
        w_out_start_next   = r_out_start;
        w_out_stop_next    = r_out_stop;
        w_out_data_next    = r_out_data;
        w_frame_error_next = 1'b0;
        w_sync_error_next  = 1'b0;
        w_ready0           = 1'b0;
        w_ready1           = 1'b0;
        w_xfer             = 1'b0;
        w_last             = 1'b0;

        unique case (r_state)
            StIdle: begin
                // Orphan pixels are swallowed; a source showing start is never drained.
                w_ready0          = w_drain0;
                w_ready1          = w_drain1;
                w_sync_error_next = w_drain0 || w_drain1;
                if (w_req0 || w_req1) begin
                    w_state_next = StLocked;
                    w_count_next = '0;
                    if (w_req0 && (!w_req1 || r_last_grant)) begin
                        w_grant_next = 2'b01;
                    end else begin
                        w_grant_next = 2'b10;
                    end
                end
            end
            StLocked: begin
                w_ready0 = r_grant[0] && w_out_free;
                w_ready1 = r_grant[1] && w_out_free;
                w_xfer   = w_sel_valid && w_out_free;
                w_last   = w_sel_stop || (r_count == LastIdx);
                if (w_xfer) begin
                    w_out_valid_next   = 1'b1;
                    w_out_data_next    = w_sel_data;
                    w_out_start_next   = (r_count == '0);
                    w_out_stop_next    = w_last;
                    w_frame_error_next = (w_sel_stop && (r_count != LastIdx))
                                      || (!w_sel_stop && (r_count == LastIdx))
                                      || (w_sel_start && (r_count != '0));
                    if (w_last) begin
                        w_state_next      = StIdle;
                        w_last_grant_next = w_sel;
                        w_grant_next      = 2'b00;
                        w_count_next      = '0;
                    end else begin
                        w_count_next = r_count + 1'b1;
                    end
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= StIdle;
            r_last_grant  <= 1'b1;
            r_count       <= '0;
            r_grant       <= 2'b00;
            r_out_valid   <= 1'b0;
            r_out_start   <= 1'b0;
            r_out_stop    <= 1'b0;
            r_out_data    <= '0;
            r_frame_error <= 1'b0;
            r_sync_error  <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_last_grant  <= w_last_grant_next;
            r_count       <= w_count_next;
            r_grant       <= w_grant_next;
            r_out_valid   <= w_out_valid_next;
            r_out_start   <= w_out_start_next;
            r_out_stop    <= w_out_stop_next;
            r_out_data    <= w_out_data_next;
            r_frame_error <= w_frame_error_next;
            r_sync_error  <= w_sync_error_next;
        end
    end

    // Ready is combinational; hold it low while reset is asserted.
    assign i_src0.ready  = w_ready0 && !i_reset;
    assign i_src1.ready  = w_ready1 && !i_reset;
    assign o_dst.valid   = r_out_valid;
    assign o_dst.start   = r_out_start;
    assign o_dst.stop    = r_out_stop;
    assign o_dst.data    = r_out_data;
    assign o_grant       = r_grant;
    assign o_frame_error = r_frame_error;
    assign o_sync_error  = r_sync_error;
endmodule

// File: tb/tb_image_frame_arbiter.sv
// Testbench for image_frame_arbiter with a 4x2 image (8 pixels per frame).
module tb_image_frame_arbiter;
    localparam int unsigned ImageWidth  = 4;
    localparam int unsigned ImageHeight = 2;
    localparam int unsigned DataWidth   = 24;
    localparam int          N           = ImageWidth * ImageHeight;

    typedef struct packed {
        logic [23:0] data;
        logic        start;
        logic        stop;
    } pix_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] grant;
    logic       frame_error, sync_error;

    always #5 clk = ~clk;

    image_pipe_if #(.DataWidth(DataWidth)) src0 ();
    image_pipe_if #(.DataWidth(DataWidth)) src1 ();
    image_pipe_if #(.DataWidth(DataWidth)) dst ();

    image_frame_arbiter #(
        .ImageWidth (ImageWidth),
        .ImageHeight(ImageHeight),
        .DataWidth  (DataWidth)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_src0       (src0),
        .i_src1       (src1),
        .o_dst        (dst),
        .o_grant      (grant),
        .o_frame_error(frame_error),
        .o_sync_error (sync_error)
    );

    int   n_assert = 0;
    int   n_fail   = 0;
    pix_t q0[$];
    pix_t q1[$];
    pix_t oq[$];          // pixels expected in the output register
    int   order[$];       // source of each frame as it starts on the output
    int   m_active = -1;  // source owning the pipe, -1 when idle
    int   m_idx    = 0;   // pixels accepted so far in the current frame
    logic m_last   = 1'b1;
    logic e_ferr   = 1'b0;
    logic e_sync   = 1'b0;
    int   vprob    = 100;
    int   rmode    = 0;
    logic tog      = 1'b1;
    int   cnt_ferr = 0;
    int   cnt_sync = 0;
    logic prev_stall = 1'b0;
    logic [23:0] prev_data;
    logic        prev_start, prev_stop;

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int get_order(input int i);
        return (i < order.size()) ? order[i] : -1;
    endfunction

    task automatic push_src(input int s, input pix_t p);
        if (s == 0) q0.push_back(p);
        else q1.push_back(p);
    endtask

    task automatic add_frame(input int s, input int len, input int base);
        pix_t p;
        for (int i = 0; i < len; i++) begin
            p.data  = {(s == 1), 23'(base + i)};
            p.start = (i == 0);
            p.stop  = (i == len - 1);
            push_src(s, p);
        end
    endtask

    // One clock cycle: drive sources, check every output against the model, advance model.
    task automatic cycle();
        logic       v0, v1, rdy, exp_ov, er0, er1, req0, req1, last, nf, ns, hit;
        logic [1:0] eg;
        pix_t       p0, p1, p, o;
        p0 = '0;
        p1 = '0;
        v0 = (q0.size() > 0) && (int'($urandom_range(99)) < vprob);
        v1 = (q1.size() > 0) && (int'($urandom_range(99)) < vprob);
        if (v0) p0 = q0[0];
        if (v1) p1 = q1[0];
        src0.valid = v0; src0.data = p0.data; src0.start = p0.start; src0.stop = p0.stop;
        src1.valid = v1; src1.data = p1.data; src1.start = p1.start; src1.stop = p1.stop;
        case (rmode)
            0:       rdy = 1'b1;
            1:       begin rdy = tog; tog = !tog; end
            default: rdy = (int'($urandom_range(99)) < 70);
        endcase
        dst.ready = rdy;

        @(negedge clk);
        if (frame_error) cnt_ferr++;
        if (sync_error) cnt_sync++;
        exp_ov = (oq.size() != 0);
        chk_bit("out_valid", dst.valid, exp_ov);
        if (exp_ov) begin
            chk_word("out_data", 32'(dst.data), 32'(oq[0].data));
            chk_bit("out_start", dst.start, oq[0].start);
            chk_bit("out_stop", dst.stop, oq[0].stop);
        end
        if (prev_stall) begin
            chk_word("stall_data", 32'(dst.data), 32'(prev_data));
            chk_bit("stall_start", dst.start, prev_start);
            chk_bit("stall_stop", dst.stop, prev_stop);
        end
        eg = (m_active == 0) ? 2'b01 : (m_active == 1) ? 2'b10 : 2'b00;
        chk_word("grant", 32'(grant), 32'(eg));
        chk_bit("frame_error", frame_error, e_ferr);
        chk_bit("sync_error", sync_error, e_sync);
        if (m_active < 0) begin
            er0 = v0 && !p0.start;
            er1 = v1 && !p1.start;
        end else begin
            er0 = (m_active == 0) && (!exp_ov || rdy);
            er1 = (m_active == 1) && (!exp_ov || rdy);
        end
        chk_bit("in0_ready", src0.ready, er0);
        chk_bit("in1_ready", src1.ready, er1);
        prev_stall = dst.valid && !rdy;
        prev_data  = dst.data;
        prev_start = dst.start;
        prev_stop  = dst.stop;

        nf = 1'b0;
        ns = 1'b0;
        if (exp_ov && rdy) void'(oq.pop_front());
        if (m_active < 0) begin
            if (er0) void'(q0.pop_front());
            if (er1) void'(q1.pop_front());
            ns   = er0 || er1;
            req0 = v0 && p0.start;
            req1 = v1 && p1.start;
            if (req0 && req1) m_active = m_last ? 0 : 1;
            else if (req0) m_active = 0;
            else if (req1) m_active = 1;
            m_idx = 0;
        end else begin
            hit = (m_active == 0) ? (v0 && er0) : (v1 && er1);
            if (hit) begin
                if (m_active == 0) p = q0.pop_front();
                else p = q1.pop_front();
                last = p.stop || (m_idx == N - 1);
                nf = (p.stop && m_idx < N - 1) || (!p.stop && m_idx == N - 1)
                  || (p.start && m_idx > 0);
                if (m_idx == 0) order.push_back(m_active);
                o.data  = p.data;
                o.start = (m_idx == 0);
                o.stop  = last;
                oq.push_back(o);
                if (last) begin
                    m_last   = (m_active == 1);
                    m_active = -1;
                end else begin
                    m_idx++;
                end
            end
        end
        e_ferr = nf;
        e_sync = ns;
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_idle(input string tag, input int max_cycles);
        int   n;
        logic idle;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || oq.size() != 0 || m_active >= 0)
               && n < max_cycles) begin
            cycle();
            n++;
        end
        idle = (q0.size() == 0 && q1.size() == 0 && oq.size() == 0 && m_active < 0);
        chk_bit({tag, "_drained"}, idle, 1'b1);
        cycle();
        cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        src0.valid = 1'b0; src0.start = 1'b0; src0.stop = 1'b0; src0.data = '0;
        src1.valid = 1'b0; src1.start = 1'b0; src1.stop = 1'b0; src1.data = '0;
        dst.ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q0.delete(); q1.delete(); oq.delete();
        m_active = -1; m_idx = 0; m_last = 1'b1;
        e_ferr = 1'b0; e_sync = 1'b0; prev_stall = 1'b0;
        @(negedge clk);
        chk_bit("rst_out_valid", dst.valid, 1'b0);
        chk_word("rst_out_data", 32'(dst.data), 32'h0);
        chk_bit("rst_out_start", dst.start, 1'b0);
        chk_bit("rst_out_stop", dst.stop, 1'b0);
        chk_word("rst_grant", 32'(grant), 32'h0);
        chk_bit("rst_frame_error", frame_error, 1'b0);
        chk_bit("rst_sync_error", sync_error, 1'b0);
        chk_bit("rst_in0_ready", src0.ready, 1'b0);
        chk_bit("rst_in1_ready", src1.ready, 1'b0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   len, n;
        pix_t p;

        // Reset state
        do_reset();

        // Single source, one well-formed frame
        order.delete(); cnt_ferr = 0; cnt_sync = 0;
        add_frame(0, N, 1);
        run_until_idle("single", 100);
        chk_word("single_frames", 32'(order.size()), 32'd1);
        chk_word("single_src", 32'(get_order(0)), 32'd0);
        chk_word("single_ferr", 32'(cnt_ferr), 32'd0);
        chk_word("single_sync", 32'(cnt_sync), 32'd0);

        // Tie from reset, then round-robin over three frames each
        do_reset();
        order.delete();
        for (int f = 0; f < 3; f++) begin
            add_frame(0, N, 16 * f);
            add_frame(1, N, 16 * f + 8);
        end
        run_until_idle("rr", 300);
        chk_word("rr_frames", 32'(order.size()), 32'd6);
        for (int i = 0; i < 6; i++) chk_word("rr_order", 32'(get_order(i)), 32'(i % 2));

        // Backpressure: out_ready alternates through the frame
        rmode = 1; tog = 1'b1;
        add_frame(0, N, 32'h40);
        run_until_idle("bp", 100);
        rmode = 0;

        // Short frame on in1 while in0 also waits
        order.delete(); cnt_ferr = 0;
        add_frame(1, 5, 32'h60);
        add_frame(0, N, 32'h70);
        run_until_idle("short", 100);
        chk_word("short_ferr", 32'(cnt_ferr), 32'd1);
        chk_word("short_first", 32'(get_order(0)), 32'd1);
        chk_word("short_next", 32'(get_order(1)), 32'd0);

        // Long frame: stop forced at pixel N, remainder drained as orphans
        cnt_ferr = 0; cnt_sync = 0;
        add_frame(0, N + 2, 32'h80);
        run_until_idle("long", 100);
        chk_word("long_ferr", 32'(cnt_ferr), 32'd1);
        chk_word("long_sync", 32'(cnt_sync), 32'd2);

        // Reset in the middle of a frame, then a tie resolves to source 0
        add_frame(0, N, 32'h90);
        n = 0;
        while (!(m_active == 0 && m_idx == 3) && n < 50) begin
            cycle();
            n++;
        end
        chk_bit("midrst_reached", (m_active == 0 && m_idx == 3), 1'b1);
        do_reset();
        order.delete();
        add_frame(1, N, 32'hA0);
        add_frame(0, N, 32'hB0);
        run_until_idle("midrst", 100);
        chk_word("midrst_first", 32'(get_order(0)), 32'd0);

        // Random traffic: random lengths, orphans, valid gaps and backpressure
        vprob = 70; rmode = 2;
        for (int f = 0; f < 12; f++) begin
            for (int s = 0; s < 2; s++) begin
                if ($urandom_range(9) == 0) begin
                    p.data  = {(s == 1), 23'($urandom)};
                    p.start = 1'b0;
                    p.stop  = 1'b0;
                    push_src(s, p);
                end else begin
                    len = int'($urandom_range(N + 2, 1));
                    add_frame(s, len, int'($urandom_range(32'h3FFFFF)));
                end
            end
        end
        run_until_idle("random", 5000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/image_frame_arbiter.md
# image_frame_arbiter

Two-source, frame-granular arbiter for image pipes. It shares one downstream image pipe (pixel data plus start/stop/valid/ready) between two upstream frame sources. Grant is locked for a whole frame, from its start pixel to its last pixel, and alternates round-robin between frames. It also enforces the frame pixel count (ImageWidth × ImageHeight), so a malformed source cannot hold the downstream pipe indefinitely.

## Interface
- ImageWidth, 100, pixels per line
- ImageHeight, 100, lines per frame
- DataWidth, 24, pixel data width (3 × 8-bit colour)
- clock  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- in0_data / in1_data  in  DataWidth  source pixel data
- in0_start / in1_start  in  1  first pixel of frame
- in0_stop / in1_stop  in  1  last pixel of frame
- in0_valid / in1_valid  in  1  source pixel valid
- in0_ready / in1_ready  out  1  arbiter accepts pixel
- out_data  out  DataWidth  registered pixel data
- out_start  out  1  registered first-pixel flag
- out_stop  out  1  registered last-pixel flag
- out_valid  out  1  output pixel valid
- out_ready  in  1  downstream accepts pixel
- grant  out  2  one-hot active source; 2'b00 when idle
- frame_error  out  1  one-cycle pulse: frame length violation
- sync_error  out  1  one-cycle pulse: orphan pixel drained while idle

## Operation
- Transfer on any pipe occurs when valid && ready in the same cycle.
- FSM states are IDLE and LOCKED. Register last_grant records the most recently served source.
- IDLE:
  - Source k requests when ink_valid && ink_start.
  - One requester: grant it.
  - Both request: grant the source != last_grant.
  - On grant: go to LOCKED, clear pixel count to 0, set grant one-hot.
  - No transfer happens in the grant cycle; the arbitration bubble is 1 cycle.
  - A source with valid && !start while IDLE is drained: ready=1, data discarded, sync_error pulses. If both sources are orphan, both are drained and there is a single pulse.
  - A source that is requesting (has start) is never drained.
- LOCKED:
  - ink_ready = granted(k) && (!out_valid || out_ready).
  - The non-granted source's ready is 0.
  - On each granted transfer:
    - out_data ← in_data
    - out_start ← (count == 0), regardless of in_start
    - out_stop ← in_stop || (count == N−1), where N = ImageWidth·ImageHeight
    - count ← count+1
  - Last pixel = in_stop || count == N−1. On its transfer: go to IDLE, set last_grant ← granted source, set grant ← 0.
  - frame_error pulses on the transfer cycle if any of the following holds:
    - in_stop with count < N−1 (short frame)
    - count == N−1 without in_stop (long frame; output stop is forced and the remaining source pixels are then handled as orphans in IDLE)
    - in_start with count > 0
- count width is clog2(N). It never exceeds N−1 and does not wrap.
- Output register: out_valid is set on transfer, and cleared when out_ready && no new transfer.

## Timing
- Reset values:
  - state IDLE
  - last_grant = 1 (source 0 wins the first tie)
  - count 0, grant 0
  - out_valid 0, out_start 0, out_stop 0, out_data 0
  - in0_ready 0, in1_ready 0
  - frame_error 0, sync_error 0
- Reset mid-frame aborts immediately. Downstream receives no stop for the partial frame.
- Latency is 1 cycle from input transfer to out_valid.
- Throughput is 1 pixel/cycle while out_ready is held high.
- in_ready combinationally depends on out_ready (no skid buffer).
- Frame-to-frame gap is at least 1 cycle (last-pixel transfer cycle → IDLE arbitration cycle → first pixel).
- Error pulses are registered and assert the cycle after the offending transfer, aligned with out_valid of that pixel.
- out_* hold stable while out_valid && !out_ready.

## Test plan
Benches use ImageWidth=4, ImageHeight=2 (N=8), DataWidth=24.
- **Single source:** in0 sends 8 pixels 0x000001..0x000008 with start on 1st and stop on 8th, out_ready=1.
  - grant=01 one cycle after in0 start is seen.
  - out shows 8 pixels with start on 0x000001 and stop on 0x000008.
  - grant=00 after; no errors.
- **Tie and round-robin:** both sources present start at the same cycle from reset, each sending 3 frames.
  - Output frame order is 0,1,0,1,0,1.
  - Frames never interleave.
  - The non-granted ready stays 0 throughout.
- **Backpressure:** out_ready toggles 1,0,1,0 during a frame.
  - No pixel is lost or duplicated.
  - out_data is stable while stalled.
  - in0_ready=0 whenever out_valid && !out_ready.
- **Short frame:** in1 asserts stop on pixel 5.
  - out_stop on pixel 5.
  - frame_error pulses once.
  - Arbiter returns to IDLE and grants in0 next if it is requesting.
- **Long frame / orphan:** in0 sends 10 pixels, stop on 10th.
  - out_stop is forced on pixel 8 and frame_error pulses.
  - Pixels 9–10 are drained with sync_error pulses; out_valid stays 0 for them.
- **Reset mid-frame:** reset for 1 cycle after pixel 3.
  - All outputs are 0 the next cycle.
  - A new start from in1 is granted as in IDLE (tie → source 0).
